// File: rtl/line_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : line_memory                                            |
// | Description : Main-memory line model behind the data cache. One      |
// |               256-bit line read or write per request, acknowledged   |
// |               with a one-cycle pulse a fixed LATENCY after accept.   |
// |               Optional feature macro: LINE_MEMORY_ABORT_EN (dropping |
// |               enable_i while waiting cancels the request).           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module line_memory #(
   parameter int DEPTH_LINES = 512,
   parameter int LATENCY     = 10
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o
);

   localparam int         IDX_W    = $clog2(DEPTH_LINES);
   localparam logic [7:0] CNT_LAST = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   // Line storage; deliberately never reset so the bench can preload it.
   logic [255:0] mem [DEPTH_LINES];

   state_t             state_q, state_d;
   logic [7:0]         cnt_q,   cnt_d;
   logic               wr_q,    wr_d;
   logic [IDX_W-1:0]   idx_q,   idx_d;
   logic [255:0]       wdata_q, wdata_d;
   logic               ack_q,   ack_d;
   logic [255:0]       data_q,  data_d;
   logic               mem_we;

   // Byte-offset and above-index address bits have no meaning here.
   wire logic unused_addr_bits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

   // Next-state, request capture and completion decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      ack_d   = 1'b0;
      data_d  = data_q;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               wr_d    = write_i;
               idx_d   = addr_i[5+IDX_W-1:5];
               wdata_d = data_i;
               cnt_d   = 8'd0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
`ifdef LINE_MEMORY_ABORT_EN
            // Abort outranks completion, even on the final wait cycle.
            if (!enable_i) begin
               cnt_d   = 8'd0;
               state_d = ST_IDLE;
            end else
`endif
            if (cnt_q == CNT_LAST) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               // Commit happens before the ack so read-after-write sees it.
               if (wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  data_d = mem[idx_q];
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
      end
   end

   // Array write port; a reset on the commit edge drops the pending write.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign ack_o  = ack_q;
   assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_line_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_line_memory                                         |
// | Description : Self-checking bench for line_memory: directed cases    |
// |               with literal expectations plus randomized traffic      |
// |               checked every cycle against a countdown-based model.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_line_memory;

   localparam int LAT   = 10;
   localparam int DEPTH = 512;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         enable = 1'b0;
   logic         write = 1'b0;
   logic [31:0]  addr = '0;
   logic [255:0] data = '0;
   logic         ack_o;
   logic [255:0] data_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   line_memory #(.DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .enable_i (enable),
      .write_i  (write),
      .addr_i   (addr),
      .data_i   (data),
      .ack_o    (ack_o),
      .data_o   (data_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- behavioural model ----------------
   logic [255:0] mmem [DEPTH];
   bit           m_busy = 1'b0;
   int           m_rem  = 0;
   bit           m_wr   = 1'b0;
   int           m_idx  = 0;
   logic [255:0] m_wd   = '0;
   logic         exp_ack = 1'b0;
   logic [255:0] exp_data = '0;

   // Request completes LAT edges after acceptance; ack lasts one cycle.
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0; exp_ack = 1'b0; exp_data = '0;
      end else if (exp_ack) begin
         exp_ack = 1'b0;
      end else if (m_busy) begin
`ifdef LINE_MEMORY_ABORT_EN
         if (!enable) m_busy = 1'b0; else
`endif
         begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
               m_busy  = 1'b0;
               exp_ack = 1'b1;
               if (m_wr) mmem[m_idx] = m_wd;
               else      exp_data = mmem[m_idx];
            end
         end
      end else if (enable) begin
         m_busy = 1'b1;
         m_rem  = LAT;
         m_wr   = write;
         m_idx  = int'(addr >> 5) % DEPTH;
         m_wd   = data;
      end
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("ack_cycle", {255'd0, ack_o}, {255'd0, exp_ack});
         check("data_cycle", data_o, exp_data);
      end
   end

   // Issue one request; returns edges from acceptance to the ack (0 = timeout).
   task automatic req(input bit w, input logic [31:0] a, input logic [255:0] d,
                      input bit hold, input bit scramble, output int lat);
      @(negedge clk);
      enable = 1'b1; write = w; addr = a; data = d;
      @(posedge clk);
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
         if (scramble && ($urandom_range(0, 3) == 0)) begin
            addr = $urandom; data = rand256(); write = 1'($urandom);
         end
      end while (!ack_o && lat < 100);
      if (!ack_o) begin
         check("req_timeout", 256'(lat), 256'(LAT));
         lat = 0;
      end
      @(negedge clk);
      if (!hold) enable = 1'b0;
   endtask

   logic [255:0] c_a5, c_pat, c_l5, c_l6, c_l9, c_d9, c_wr, v;
   int lat, n, first, second;
   bit acked;

   initial begin
      c_a5  = {32{8'hA5}};
      c_pat = 256'h12345678_9ABCDEF0_0FEDCBA9_87654321_DEADBEEF_CAFEF00D_13579BDF_2468ACE0;
      c_l5  = {32{8'h55}};
      c_l6  = {32{8'h66}};
      c_l9  = {32{8'h99}};
      c_d9  = {32{8'hD9}};
      c_wr  = {16{16'hBEEF}};
      for (int i = 0; i < DEPTH; i++) begin
         v = rand256();
         dut.mem[i] = v; mmem[i] = v;
      end
      dut.mem[3] = c_a5;   mmem[3] = c_a5;
      dut.mem[5] = c_l5;   mmem[5] = c_l5;
      dut.mem[6] = c_l6;   mmem[6] = c_l6;
      dut.mem[7] = '0;     mmem[7] = '0;
      dut.mem[9] = c_l9;   mmem[9] = c_l9;

      @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      check("reset_ack", {255'd0, ack_o}, 256'd0);
      check("reset_data", data_o, 256'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset read of line 3.
      req(1'b0, 32'h60, '0, 1'b0, 1'b0, lat);
      check("rd3_latency", 256'(lat), 256'd10);
      check("rd3_data", data_o, c_a5);

      // Write then read at 0x400; data_o must hold across the write ack.
      req(1'b1, 32'h0000_0400, c_pat, 1'b0, 1'b0, lat);
      check("wr_latency", 256'(lat), 256'd10);
      check("wr_ack_data_hold", data_o, c_a5);
      req(1'b0, 32'h0000_0400, '0, 1'b0, 1'b0, lat);
      check("raw_data", data_o, c_pat);

      // Back-to-back: enable held through ack, address changed during WAIT.
      @(negedge clk);
      enable = 1'b1; write = 1'b0; addr = 32'hA0;
      @(posedge clk);
      n = 0; first = 0; second = 0;
      while (second == 0 && n < 60) begin
         @(posedge clk);
         n++;
         #1;
         if (n == 3) addr = 32'hC0;
         if (ack_o) begin
            if (first == 0) begin
               first = n;
               check("b2b_first_data", data_o, c_l5);
            end else begin
               second = n;
            end
         end
      end
      @(negedge clk);
      enable = 1'b0;
      check("b2b_first_latency", 256'(first), 256'd10);
      check("b2b_spacing", 256'(second - first), 256'd12);
      check("b2b_second_data", data_o, c_l6);

      // Reset in the middle of a write to line 7.
      @(negedge clk);
      enable = 1'b1; write = 1'b1; addr = 32'hE0; data = '1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1; enable = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_ack", {255'd0, ack_o}, 256'd0);
      check("midrst_data", data_o, 256'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      req(1'b0, 32'hE0, '0, 1'b0, 1'b0, lat);
      check("midrst_line7", data_o, 256'd0);

      // Wrap: 0x4020 aliases onto line 1.
      req(1'b1, 32'h0000_4020, c_wr, 1'b0, 1'b0, lat);
      req(1'b0, 32'h0000_0020, '0, 1'b0, 1'b0, lat);
      check("wrap_data", data_o, c_wr);

      // Enable dropped at cnt=4 on a write to line 9.
      @(negedge clk);
      enable = 1'b1; write = 1'b1; addr = 32'h120; data = c_d9;
      @(posedge clk);
      repeat (4) @(posedge clk);
      n = 4;
      @(negedge clk);
      enable = 1'b0;
      acked = 1'b0;
      while (!acked && n < 20) begin
         @(posedge clk);
         n++;
         #1;
         if (ack_o) acked = 1'b1;
      end
`ifdef LINE_MEMORY_ABORT_EN
      check("abort_no_ack", {255'd0, acked}, 256'd0);
`else
      check("noabort_ack_edge", 256'(n), 256'd10);
`endif
      repeat (3) @(negedge clk);
      req(1'b0, 32'h120, '0, 1'b0, 1'b0, lat);
`ifdef LINE_MEMORY_ABORT_EN
      check("abort_line9", data_o, c_l9);
`else
      check("noabort_line9", data_o, c_d9);
`endif

      // Randomized traffic on a small index window to hit read-after-write.
      for (int it = 0; it < 60; it++) begin
         logic [31:0] ra;
         ra = $urandom;
         ra[13:5] = 9'($urandom_range(0, 15));
         req(1'($urandom), ra, rand256(), ($urandom_range(0, 3) == 0),
             1'b1, lat);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      @(negedge clk);
      enable = 1'b0;
      repeat (15) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
